operand_stage: RTL and testbench
================================

Name: operand_stage

Overview:
- ID/EX pipeline stage directly downstream of the 8x16 register file.
- Captures the decoded instruction and its three register operands (Rn, Rm, Rd-read) into the EX-stage register.
- Resolves RAW hazards by forwarding from MEM and WB, and inserts bubbles with a decode stall on load-use.
- Honours EX backpressure and branch flush.

Parameters:
- DW, 16, datapath width.
- RW, 3, register-number width (2**RW architectural registers).
- CW, 8, width of opaque control bundle passed through to EX.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- id_valid  in  1  decode presents an instruction
- id_stall  out  1  decode must hold instruction (combinational)
- id_rn_num, id_rm_num, id_rd_num  in  RW each  source register numbers (also drive regfile read ports)
- id_use_rn, id_use_rm, id_use_rd  in  1 each  source actually read
- id_rn_data, id_rm_data, id_rd_data  in  DW each  regfile read data
- id_dest_num  in  RW  destination register
- id_writes  in  1  instruction writes a register
- id_is_load  in  1  instruction is a load
- id_ctrl  in  CW  control bundle
- flush  in  1  kill the instruction in decode and the one in EX
- ex_ready  in  1  EX accepts the held instruction this cycle
- ex_valid  out  1  EX register holds a live instruction
- ex_a, ex_b, ex_c  out  DW each  forwarded Rn, Rm, Rd operands
- ex_dest_num  out  RW
- ex_writes, ex_is_load  out  1 each
- ex_ctrl  out  CW
- mem_valid, mem_writes, mem_is_load  in  1 each  MEM-stage info
- mem_dest_num  in  RW
- mem_result  in  DW  ALU result in MEM (invalid for loads)
- wb_write  in  1  regfile write enable this cycle
- wb_num  in  RW
- wb_data  in  DW

Behaviour:
- Reset (async, reset_n low): ex_valid=0, ex_writes=0, ex_is_load=0; ex_a/ex_b/ex_c=0, ex_dest_num=0, ex_ctrl=0. Reset mid-stall drops everything; no replay.
- Operand select, per source, priority high to low:
  - MEM hit: mem_valid & mem_writes & !mem_is_load & dest match -> mem_result.
  - WB hit: wb_write & wb_num match -> wb_data. Covers the write-same-cycle case: the regfile updates at the edge, so its read data is stale.
  - Otherwise regfile data.
  - Unused sources (use bit 0) are still captured with the selected value but never cause a hazard.
- Load-use hazard, hz=1 when id_valid and any used source matches either of:
  - ex_valid & ex_writes & ex_is_load & ex_dest_num.
  - mem_valid & mem_writes & mem_is_load & mem_dest_num.
  - A load therefore costs 2 stall cycles when adjacent and 1 when separated by one instruction.
- adv = !ex_valid | ex_ready (EX register may be overwritten).
- id_stall = id_valid & !flush & (hz | !adv).
- Clock edge, first match wins:
  - flush=1: ex_valid<=0 (bubble); decode instruction discarded.
  - adv & id_valid & !hz: capture all fields, ex_valid<=1.
  - adv & (hz | !id_valid): ex_valid<=0 (bubble).
  - !adv: hold all EX fields unchanged.
- Flush during backpressure clears ex_valid regardless of ex_ready.
- Latency: 1 cycle from accepted decode to ex_valid. Throughput: 1 per cycle with no hazard or backpressure.
- Data fields are don't-care when ex_valid=0, but ex_writes and ex_is_load are forced to 0 on a bubble so downstream matching is safe.
- Equal source numbers (e.g. Rn=Rm=R3) each forward independently and identically.

Test Plan:
- Back-to-back ALU ops: R2<=R1+R1 then R3<=R2+R2, with mem_result=0x0010 -> second op captures ex_a=ex_b=0x0010, no stall.
- WB collision: regfile R5=0x1111 while wb_write R5=0xBEEF in the same cycle -> ex_a=0xBEEF.
- MEM and WB both target R4, with mem_result=0x00AA and wb_data=0x00BB -> ex_a=0x00AA.
- Load-use: LDR R1 followed by ADD using R1 -> id_stall high for 2 cycles with two bubbles (ex_valid=0), then ex_a=wb_data=0x1234.
- Backpressure: ex_ready=0 for 3 cycles while ex_valid=1 -> EX fields stable, id_stall=1; flush in cycle 2 -> ex_valid=0 next edge.
- Reset_n asserted mid-stall -> all outputs zero immediately (asynchronously); first instruction after release is captured normally.

Source files
------------

// File: rtl/operand_stage.sv
// ID/EX operand stage: MEM/WB forwarding, load-use stall,
// EX backpressure and branch flush in front of the EX register.
module operand_stage #(
  parameter int DW = 16,
  parameter int RW = 3,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          id_valid,
  output logic          id_stall,
  input  logic [RW-1:0] id_rn_num,
  input  logic [RW-1:0] id_rm_num,
  input  logic [RW-1:0] id_rd_num,
  input  logic          id_use_rn,
  input  logic          id_use_rm,
  input  logic          id_use_rd,
  input  logic [DW-1:0] id_rn_data,
  input  logic [DW-1:0] id_rm_data,
  input  logic [DW-1:0] id_rd_data,
  input  logic [RW-1:0] id_dest_num,
  input  logic          id_writes,
  input  logic          id_is_load,
  input  logic [CW-1:0] id_ctrl,
  input  logic          flush,
  input  logic          ex_ready,
  output logic          ex_valid,
  output logic [DW-1:0] ex_a,
  output logic [DW-1:0] ex_b,
  output logic [DW-1:0] ex_c,
  output logic [RW-1:0] ex_dest_num,
  output logic          ex_writes,
  output logic          ex_is_load,
  output logic [CW-1:0] ex_ctrl,
  input  logic          mem_valid,
  input  logic          mem_writes,
  input  logic          mem_is_load,
  input  logic [RW-1:0] mem_dest_num,
  input  logic [DW-1:0] mem_result,
  input  logic          wb_write,
  input  logic [RW-1:0] wb_num,
  input  logic [DW-1:0] wb_data
);

  logic          valid_q, valid_d;
  logic          writes_q, writes_d;
  logic          load_q, load_d;
  logic [DW-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [RW-1:0] dest_q, dest_d;
  logic [CW-1:0] ctrl_q, ctrl_d;

  logic          mem_fw, ld_ex, ld_mem;
  logic          hz, adv;
  logic [DW-1:0] op_a, op_b, op_c;

  // MEM result only forwards for ALU ops; loads have no data yet.
  assign mem_fw = mem_valid & mem_writes & ~mem_is_load;
  assign ld_ex  = valid_q & writes_q & load_q;
  assign ld_mem = mem_valid & mem_writes & mem_is_load;

  function automatic logic [DW-1:0] pick(
    input logic [RW-1:0] n,
    input logic [DW-1:0] rf,
    input logic          mfw,
    input logic [RW-1:0] mn,
    input logic [DW-1:0] mr,
    input logic          ww,
    input logic [RW-1:0] wn,
    input logic [DW-1:0] wd
  );
    logic [DW-1:0] r;
    if (mfw && n == mn)     r = mr;
    else if (ww && n == wn) r = wd;
    else                    r = rf;
    return r;
  endfunction

  function automatic logic ldhit(
    input logic          use_i,
    input logic [RW-1:0] n,
    input logic          lx,
    input logic [RW-1:0] xn,
    input logic          lm,
    input logic [RW-1:0] mn
  );
    return use_i & ((lx & (n == xn)) | (lm & (n == mn)));
  endfunction

  // Operand selection, hazard detection and handshake.
  always_comb begin
    op_a = pick(id_rn_num, id_rn_data, mem_fw,
                mem_dest_num, mem_result,
                wb_write, wb_num, wb_data);
    op_b = pick(id_rm_num, id_rm_data, mem_fw,
                mem_dest_num, mem_result,
                wb_write, wb_num, wb_data);
    op_c = pick(id_rd_num, id_rd_data, mem_fw,
                mem_dest_num, mem_result,
                wb_write, wb_num, wb_data);
    hz = id_valid & (
         ldhit(id_use_rn, id_rn_num, ld_ex, dest_q,
               ld_mem, mem_dest_num) |
         ldhit(id_use_rm, id_rm_num, ld_ex, dest_q,
               ld_mem, mem_dest_num) |
         ldhit(id_use_rd, id_rd_num, ld_ex, dest_q,
               ld_mem, mem_dest_num));
    adv = ~valid_q | ex_ready;
    id_stall = id_valid & ~flush & (hz | ~adv);
  end

  // EX register next state: flush, capture, bubble or hold.
  always_comb begin
    valid_d  = valid_q;
    writes_d = writes_q;
    load_d   = load_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    dest_d   = dest_q;
    ctrl_d   = ctrl_q;
    if (flush) begin
      valid_d  = 1'b0;
      writes_d = 1'b0;
      load_d   = 1'b0;
    end else if (adv && id_valid && !hz) begin
      valid_d  = 1'b1;
      writes_d = id_writes;
      load_d   = id_is_load;
      a_d      = op_a;
      b_d      = op_b;
      c_d      = op_c;
      dest_d   = id_dest_num;
      ctrl_d   = id_ctrl;
    end else if (adv) begin
      valid_d  = 1'b0;
      writes_d = 1'b0;
      load_d   = 1'b0;
    end
  end

  // EX register with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q  <= 1'b0;
      writes_q <= 1'b0;
      load_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      dest_q   <= '0;
      ctrl_q   <= '0;
    end else begin
      valid_q  <= valid_d;
      writes_q <= writes_d;
      load_q   <= load_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      dest_q   <= dest_d;
      ctrl_q   <= ctrl_d;
    end
  end

  assign ex_valid    = valid_q;
  assign ex_writes   = writes_q;
  assign ex_is_load  = load_q;
  assign ex_a        = a_q;
  assign ex_b        = b_q;
  assign ex_c        = c_q;
  assign ex_dest_num = dest_q;
  assign ex_ctrl     = ctrl_q;

endmodule

// File: tb/tb_operand_stage.sv
// Bench for operand_stage: directed plan scenarios
// plus random stimulus against a behavioural model.
module tb_operand_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        id_valid;
  logic        id_stall;
  logic [2:0]  id_rn_num, id_rm_num, id_rd_num;
  logic        id_use_rn, id_use_rm, id_use_rd;
  logic [15:0] id_rn_data, id_rm_data, id_rd_data;
  logic [2:0]  id_dest_num;
  logic        id_writes, id_is_load;
  logic [7:0]  id_ctrl;
  logic        flush, ex_ready;
  logic        ex_valid;
  logic [15:0] ex_a, ex_b, ex_c;
  logic [2:0]  ex_dest_num;
  logic        ex_writes, ex_is_load;
  logic [7:0]  ex_ctrl;
  logic        mem_valid, mem_writes, mem_is_load;
  logic [2:0]  mem_dest_num;
  logic [15:0] mem_result;
  logic        wb_write;
  logic [2:0]  wb_num;
  logic [15:0] wb_data;

  int n_chk = 0;
  int n_fail = 0;

  operand_stage dut (
    .clk(clk), .reset_n(reset_n),
    .id_valid(id_valid), .id_stall(id_stall),
    .id_rn_num(id_rn_num), .id_rm_num(id_rm_num),
    .id_rd_num(id_rd_num),
    .id_use_rn(id_use_rn), .id_use_rm(id_use_rm),
    .id_use_rd(id_use_rd),
    .id_rn_data(id_rn_data), .id_rm_data(id_rm_data),
    .id_rd_data(id_rd_data),
    .id_dest_num(id_dest_num), .id_writes(id_writes),
    .id_is_load(id_is_load), .id_ctrl(id_ctrl),
    .flush(flush), .ex_ready(ex_ready),
    .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b),
    .ex_c(ex_c), .ex_dest_num(ex_dest_num),
    .ex_writes(ex_writes), .ex_is_load(ex_is_load),
    .ex_ctrl(ex_ctrl),
    .mem_valid(mem_valid), .mem_writes(mem_writes),
    .mem_is_load(mem_is_load),
    .mem_dest_num(mem_dest_num), .mem_result(mem_result),
    .wb_write(wb_write), .wb_num(wb_num),
    .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr;
    id_valid = 0; id_writes = 0; id_is_load = 0;
    id_rn_num = 0; id_rm_num = 0; id_rd_num = 0;
    id_use_rn = 0; id_use_rm = 0; id_use_rd = 0;
    id_rn_data = 0; id_rm_data = 0; id_rd_data = 0;
    id_dest_num = 0; id_ctrl = 0;
    flush = 0; ex_ready = 1;
    mem_valid = 0; mem_writes = 0; mem_is_load = 0;
    mem_dest_num = 0; mem_result = 0;
    wb_write = 0; wb_num = 0; wb_data = 0;
  endtask

  // ALU op reading rn and rm.
  task automatic alu(input logic [2:0] rn,
                     input logic [2:0] rm,
                     input logic [15:0] dn,
                     input logic [15:0] dm,
                     input logic [2:0] dst);
    id_valid = 1; id_writes = 1; id_is_load = 0;
    id_rn_num = rn; id_rm_num = rm;
    id_use_rn = 1; id_use_rm = 1; id_use_rd = 0;
    id_rn_data = dn; id_rm_data = dm;
    id_dest_num = dst;
  endtask

  // Behavioural model of the EX register contents.
  logic        m_v, m_w, m_l;
  logic [15:0] m_a, m_b, m_c;
  logic [2:0]  m_d;
  logic [7:0]  m_ctrl;

  function automatic logic [15:0] src(
    input logic [2:0] n, input logic [15:0] rf);
    if (mem_valid && mem_writes && !mem_is_load &&
        mem_dest_num == n)
      return mem_result;
    if (wb_write && wb_num == n)
      return wb_data;
    return rf;
  endfunction

  function automatic logic pending_load(
    input logic u, input logic [2:0] n);
    if (!u) return 1'b0;
    if (m_v && m_w && m_l && m_d == n) return 1'b1;
    if (mem_valid && mem_writes && mem_is_load &&
        mem_dest_num == n) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_ex(input string p);
    chk({p, ".valid"}, ex_valid, m_v);
    chk({p, ".writes"}, ex_writes, m_w);
    chk({p, ".load"}, ex_is_load, m_l);
    if (m_v) begin
      chk({p, ".a"}, ex_a, m_a);
      chk({p, ".b"}, ex_b, m_b);
      chk({p, ".c"}, ex_c, m_c);
      chk({p, ".dest"}, ex_dest_num, m_d);
      chk({p, ".ctrl"}, ex_ctrl, m_ctrl);
    end
  endtask

  logic [15:0] hold_a;
  int          stalls;

  initial begin
    clr();
    reset_n = 0;
    #12;
    // reset state
    chk("rst.valid", ex_valid, 0);
    chk("rst.writes", ex_writes, 0);
    chk("rst.load", ex_is_load, 0);
    chk("rst.a", ex_a, 0);
    chk("rst.ctrl", ex_ctrl, 0);
    reset_n = 1;
    tick();

    // back-to-back ALU: R2<=R1+R1 then R3<=R2+R2
    alu(1, 1, 16'h0008, 16'h0008, 2);
    tick();
    chk("b2b1.valid", ex_valid, 1);
    alu(2, 2, 16'h0000, 16'h0000, 3);
    mem_valid = 1; mem_writes = 1;
    mem_dest_num = 2; mem_result = 16'h0010;
    #1;
    chk("b2b.stall", id_stall, 0);
    tick();
    chk("b2b.a", ex_a, 16'h0010);
    chk("b2b.b", ex_b, 16'h0010);
    chk("b2b.valid", ex_valid, 1);

    // WB same-cycle write beats stale regfile data
    clr();
    alu(5, 0, 16'h1111, 16'h0, 6);
    wb_write = 1; wb_num = 5; wb_data = 16'hBEEF;
    tick();
    chk("wb.a", ex_a, 16'hBEEF);

    // MEM beats WB on the same register
    clr();
    alu(4, 0, 16'h0000, 16'h0, 6);
    mem_valid = 1; mem_writes = 1;
    mem_dest_num = 4; mem_result = 16'h00AA;
    wb_write = 1; wb_num = 4; wb_data = 16'h00BB;
    tick();
    chk("prio.a", ex_a, 16'h00AA);

    // load-use: LDR R1 then ADD R1
    clr();
    id_valid = 1; id_writes = 1; id_is_load = 1;
    id_dest_num = 1;
    tick();
    chk("ld.valid", ex_valid, 1);
    chk("ld.load", ex_is_load, 1);
    alu(1, 0, 16'h0, 16'h0, 2);
    stalls = 0;
    #1;
    if (id_stall) stalls++;
    tick();
    chk("lu.bub1", ex_valid, 0);
    mem_valid = 1; mem_writes = 1; mem_is_load = 1;
    mem_dest_num = 1;
    #1;
    if (id_stall) stalls++;
    tick();
    chk("lu.bub2", ex_valid, 0);
    chk("lu.bub2w", ex_writes, 0);
    mem_valid = 0; mem_writes = 0; mem_is_load = 0;
    wb_write = 1; wb_num = 1; wb_data = 16'h1234;
    #1;
    chk("lu.go", id_stall, 0);
    chk("lu.stalls", stalls, 2);
    tick();
    chk("lu.valid", ex_valid, 1);
    chk("lu.a", ex_a, 16'h1234);

    // backpressure with flush in the second cycle
    clr();
    alu(3, 3, 16'h0777, 16'h0777, 5);
    id_ctrl = 8'h5A;
    tick();
    hold_a = ex_a;
    chk("bp.cap", ex_a, 16'h0777);
    ex_ready = 0;
    alu(6, 6, 16'h0123, 16'h0123, 7);
    #1;
    chk("bp.stall1", id_stall, 1);
    tick();
    chk("bp.hold_a", ex_a, hold_a);
    chk("bp.hold_ctl", ex_ctrl, 8'h5A);
    chk("bp.hold_v", ex_valid, 1);
    flush = 1;
    #1;
    chk("bp.flstall", id_stall, 0);
    tick();
    chk("bp.flush", ex_valid, 0);
    flush = 0;
    #1;
    chk("bp.stall3", id_stall, 0);
    tick();
    chk("bp.after", ex_a, 16'h0123);

    // async reset in the middle of a load-use stall
    clr();
    id_valid = 1; id_writes = 1; id_is_load = 1;
    id_dest_num = 6; id_rn_data = 16'h5555;
    id_ctrl = 8'hC3;
    tick();
    alu(6, 0, 16'h0042, 16'h0, 2);
    #1;
    chk("mr.stall", id_stall, 1);
    #1;
    reset_n = 0;
    #1;
    chk("mr.valid", ex_valid, 0);
    chk("mr.load", ex_is_load, 0);
    chk("mr.a", ex_a, 0);
    chk("mr.ctrl", ex_ctrl, 0);
    chk("mr.nostall", id_stall, 0);
    reset_n = 1;
    tick();
    chk("mr.cap", ex_valid, 1);
    chk("mr.capa", ex_a, 16'h0042);

    // random phase against the model
    clr();
    reset_n = 0;
    #2;
    reset_n = 1;
    m_v = 0; m_w = 0; m_l = 0;
    m_a = 0; m_b = 0; m_c = 0; m_d = 0; m_ctrl = 0;
    tick();
    for (int i = 0; i < 2000; i++) begin
      logic hz, adv, st;
      id_valid = ($urandom_range(0, 9) < 8);
      id_rn_num = 3'($urandom_range(0, 7));
      id_rm_num = 3'($urandom_range(0, 7));
      id_rd_num = 3'($urandom_range(0, 7));
      id_use_rn = 1'($urandom);
      id_use_rm = 1'($urandom);
      id_use_rd = 1'($urandom);
      id_rn_data = 16'($urandom);
      id_rm_data = 16'($urandom);
      id_rd_data = 16'($urandom);
      id_dest_num = 3'($urandom_range(0, 7));
      id_writes = 1'($urandom);
      id_is_load = ($urandom_range(0, 2) == 0);
      id_ctrl = 8'($urandom);
      flush = ($urandom_range(0, 9) == 0);
      ex_ready = ($urandom_range(0, 3) != 0);
      mem_valid = 1'($urandom);
      mem_writes = 1'($urandom);
      mem_is_load = 1'($urandom);
      mem_dest_num = 3'($urandom_range(0, 7));
      mem_result = 16'($urandom);
      wb_write = 1'($urandom);
      wb_num = 3'($urandom_range(0, 7));
      wb_data = 16'($urandom);
      hz = id_valid &&
           (pending_load(id_use_rn, id_rn_num) ||
            pending_load(id_use_rm, id_rm_num) ||
            pending_load(id_use_rd, id_rd_num));
      adv = !m_v || ex_ready;
      st = id_valid && !flush && (hz || !adv);
      #1;
      chk("rnd.stall", id_stall, st);
      if (flush || (adv && !(id_valid && !hz))) begin
        m_v = 0; m_w = 0; m_l = 0;
      end else if (adv) begin
        m_v = 1; m_w = id_writes; m_l = id_is_load;
        m_a = src(id_rn_num, id_rn_data);
        m_b = src(id_rm_num, id_rm_data);
        m_c = src(id_rd_num, id_rd_data);
        m_d = id_dest_num; m_ctrl = id_ctrl;
      end
      tick();
      check_ex("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
